// File: rtl/i2s_pkg.sv
// Shared types for the I2S capture path: FSM states, channel codes, sample word.
package i2s_pkg;

    localparam int WORD_W = 16;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    typedef enum logic [1:0] {IDLE, ARM, SHIFT, WAIT} cap_state_t;

    typedef struct packed {
        logic              chan;
        logic [WORD_W-1:0] data;
    } i2s_sample_t;

endpackage

// File: rtl/i2s_sample_fifo.sv
// First-word-fall-through sample FIFO. The head entry is always visible on 'head'.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module i2s_sample_fifo
    import i2s_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  i2s_sample_t            push_data,
    input  logic                   pop,
    output i2s_sample_t            head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    i2s_sample_t mem [DEPTH];
    logic [AW:0] wr_cnt;
    logic [AW:0] rd_cnt;
    logic        do_push;
    logic        do_pop;

    // Counters carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_cnt == rd_cnt);
    assign full    = (wr_cnt[AW] != rd_cnt[AW]) && (wr_cnt[AW-1:0] == rd_cnt[AW-1:0]);
    assign level   = wr_cnt - rd_cnt;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_cnt[AW-1:0]];

    // Storage and pointer update; storage is cleared so the head reads zero after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_cnt[AW-1:0]] <= push_data;
                wr_cnt              <= wr_cnt + 1'b1;
            end
            if (do_pop) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2s_capture.sv
// I2S slave receiver: synchronises sclk/ws/sdi into clk, deserialises MSB-first
// channel halves with the one-bit I2S delay, and queues tagged samples in a FIFO.
module i2s_capture
    import i2s_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic                        sclk,
    input  logic                        ws,
    input  logic                        sdi,
    output logic [WORD_W-1:0]           m_data,
    output logic                        m_chan,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
    output logic                        frame_err,
    input  logic                        clr_err
);

    localparam int CNT_W = $clog2(WORD_W + 1);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ws_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic                   sclk_hist;
    logic                   sclk_s;
    logic                   ws_s;
    logic                   sdi_s;
    logic                   sclk_rise;
    logic                   ws_prev;
    logic                   ws_edge;

    cap_state_t             state;
    logic                   chan;
    logic [WORD_W-2:0]      shreg;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   last_bit;

    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   ovf_evt;
    logic                   ferr_evt;
    i2s_sample_t            push_data;
    i2s_sample_t            head;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ws_s      = ws_sync[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist;
    assign ws_edge   = (ws_s != ws_prev);
    assign last_bit  = (bit_cnt == CNT_W'(WORD_W - 1));

    // The final bit goes straight into the FIFO so the word appears one clk after its sclk_rise.
    assign push      = en & sclk_rise & (state == SHIFT) & ~ws_edge & last_bit;
    assign push_data = '{chan: chan, data: {shreg, sdi_s}};
    assign ferr_evt  = en & sclk_rise & (state == SHIFT) & ws_edge;
    assign pop       = m_valid & m_ready;
    assign ovf_evt   = push & fifo_full & ~pop;

    assign m_data    = head.data;
    assign m_chan    = head.chan;
    assign m_valid   = ~fifo_empty;

    // Bring the asynchronous I2S pins into the clk domain and keep sclk history for edge detect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= '0;
            ws_sync   <= '0;
            sdi_sync  <= '0;
            sclk_hist <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            ws_sync   <= {ws_sync[SYNC_STAGES-2:0], ws};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
            sclk_hist <= sclk_s;
        end
    end

    // ws is tracked on every bit clock, even while disabled, so re-enabling never sees a stale edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ws_prev <= 1'b0;
        end else if (sclk_rise) begin
            ws_prev <= ws_s;
        end
    end

    // Capture FSM: ARM absorbs the I2S one-bit delay after each ws edge, SHIFT collects the word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            chan    <= CH_LEFT;
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (!en) begin
            state <= IDLE;
        end else if (sclk_rise) begin
            case (state)
                IDLE: begin
                    if (ws_edge) begin
                        state <= ARM;
                        chan  <= ws_s;
                    end
                end
                ARM: begin
                    state   <= SHIFT;
                    shreg   <= {{(WORD_W-2){1'b0}}, sdi_s};
                    bit_cnt <= CNT_W'(1);
                end
                SHIFT: begin
                    if (ws_edge) begin
                        state <= ARM;
                        chan  <= ws_s;
                    end else begin
                        shreg   <= {shreg[WORD_W-3:0], sdi_s};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (last_bit) begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (ws_edge) begin
                        state <= ARM;
                        chan  <= ws_s;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky error flags; a new error event takes priority over a clear request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (ovf_evt) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (ferr_evt) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
        end
    end

    i2s_sample_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

endmodule

// File: tb/tb_i2s_capture.sv
// Bench for i2s_capture: drives I2S halves from a task and predicts captured words
// half by half from what was sent, the enable level and the FIFO occupancy.
`timescale 1ns/1ps
module tb_i2s_capture;
    import i2s_pkg::*;

    localparam real SCLK_HALF  = 488.281;
    localparam real SCLK_PER   = 976.562;
    localparam int  FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, en, sclk, ws, sdi, m_ready, clr_err;
    logic [15:0] m_data;
    logic        m_chan, m_valid, overflow, frame_err;
    logic [2:0]  fifo_level;

    i2s_capture #(.FIFO_DEPTH(FIFO_DEPTH), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .en(en), .sclk(sclk), .ws(ws), .sdi(sdi),
        .m_data(m_data), .m_chan(m_chan), .m_valid(m_valid), .m_ready(m_ready),
        .fifo_level(fifo_level), .overflow(overflow), .frame_err(frame_err),
        .clr_err(clr_err)
    );

    always #10 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [16:0] exp_q[$];
    int          mlevel  = 0;
    bit          hold    = 0;
    bit          exp_ovf = 0;
    bit          exp_ferr = 0;
    bit          lat_chk = 1;
    bit          rnd_ready = 0;
    bit          rdy_cmd = 1;
    int          beats = 0;
    bit          stalled = 0;
    logic [16:0] stall_val;

    // Consumer ready: commanded level, or random toggling in the random phase.
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : rdy_cmd;
        end
    end

    // Output monitor on the falling clk edge: beat scoreboard and stall stability.
    always @(negedge clk) begin
        if (stalled && m_valid) check("hold_stable", {m_chan, m_data}, stall_val);
        stalled   = m_valid && !m_ready;
        stall_val = {m_chan, m_data};
        if (m_valid && m_ready) begin
            beats++;
            if (exp_q.size() == 0) check("beat_extra", 32'(exp_q.size()), 32'd1);
            else check("beat", {m_chan, m_data}, exp_q.pop_front());
        end
    end

    // One ws half: ws toggles on the first sclk fall, data MSB follows one bit later.
    task automatic send_half(input logic [15:0] data, input int len, input bit mdl);
        logic wsv;
        bit   cap;
        int   b;
        wsv = ~ws;
        cap = mdl && en;
        if (cap) begin
            if (len >= 17) begin
                if (!hold) exp_q.push_back({wsv, data});
                else if (mlevel < FIFO_DEPTH) begin
                    exp_q.push_back({wsv, data});
                    mlevel++;
                end else exp_ovf = 1;
            end else exp_ferr = 1;
        end
        for (int k = 0; k < len; k++) begin
            sclk = 1'b0;
            ws   = wsv;
            sdi  = (k >= 1 && k <= 16) ? data[16-k] : 1'($urandom);
            #(SCLK_HALF);
            sclk = 1'b1;
            if (k == 16 && cap && lat_chk) begin
                b = beats;
                #80;
                check("push_latency", 32'(beats - b), 32'd1);
                #(SCLK_HALF - 80.0);
            end else begin
                #(SCLK_HALF);
            end
        end
    endtask

    task automatic drain_wait(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #2 clr_err = 1'b1;
        @(posedge clk); #2 clr_err = 1'b0;
        #1;
    endtask

    logic [15:0] rom [6] = '{16'h0001, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h5A5A, 16'hC0DE};

    initial begin
        int b;
        reset = 1'b1; en = 1'b0; clr_err = 1'b0; sclk = 1'b0; ws = 1'b0; sdi = 1'b0;
        #105;
        check("rst_valid", 32'(m_valid), 0);
        check("rst_level", 32'(fifo_level), 0);
        check("rst_data", 32'(m_data), 0);
        check("rst_chan", 32'(m_chan), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_ferr", 32'(frame_err), 0);
        reset = 1'b0;
        en    = 1'b1;
        #200;

        // Stereo frame after one priming right half
        send_half(16'($urandom), 32, 1);
        send_half(16'hA5C3, 32, 1);
        send_half(16'h1234, 32, 1);
        drain_wait("stereo_drain");

        // Backpressure: 3 frames into a 4-deep FIFO
        lat_chk = 0; hold = 1; rdy_cmd = 0; mlevel = 0;
        for (int i = 0; i < 6; i++) send_half(16'($urandom), 32, 1);
        #1;
        check("bp_level", 32'(fifo_level), 32'(mlevel));
        check("bp_overflow", 32'(overflow), 32'(exp_ovf));
        hold = 0; rdy_cmd = 1;
        drain_wait("bp_drain");
        pulse_clr();
        exp_ovf = 0;
        check("ovf_clear", 32'(overflow), 32'(exp_ovf));

        // Reset in the middle of a left half with words queued
        hold = 1; rdy_cmd = 0; mlevel = 0;
        send_half(16'($urandom), 32, 1);
        send_half(16'($urandom), 32, 1);
        if (!ws) send_half(16'($urandom), 32, 1);
        #1;
        check("pre_rst_level", 32'(fifo_level), 32'(mlevel));
        fork
            send_half(16'($urandom), 32, 0);
            begin
                #(8 * SCLK_PER);
                reset = 1'b1;
                #1;
                check("mid_rst_valid", 32'(m_valid), 0);
                check("mid_rst_level", 32'(fifo_level), 0);
                check("mid_rst_data", 32'(m_data), 0);
                check("mid_rst_chan", 32'(m_chan), 0);
                exp_q.delete();
                mlevel = 0; hold = 0; rdy_cmd = 1;
                #(6 * SCLK_PER);
                reset = 1'b0;
            end
        join
        check("post_rst_valid", 32'(m_valid), 0);
        lat_chk = 1;
        send_half(16'($urandom), 32, 1);
        drain_wait("post_rst_drain");

        // Short half then a good one
        send_half(16'($urandom), 11, 1);
        send_half(16'hBEEF, 32, 1);
        check("short_ferr", 32'(frame_err), 32'(exp_ferr));
        drain_wait("short_drain");
        pulse_clr();
        exp_ferr = 0;
        check("ferr_clear", 32'(frame_err), 32'(exp_ferr));

        // Disable across a frame, re-enable mid-half
        b  = beats;
        en = 1'b0;
        send_half(16'($urandom), 32, 1);
        fork
            send_half(16'($urandom), 32, 1);
            begin
                #(12 * SCLK_PER);
                en = 1'b1;
            end
        join
        check("dis_beats", 32'(beats - b), 0);
        check("dis_level", 32'(fifo_level), 0);
        send_half(16'($urandom), 32, 1);
        drain_wait("reen_drain");

        // Playback ROM stream looped into sdi
        for (int i = 0; i < 6; i++) send_half(rom[i], 32, 1);
        drain_wait("loop_drain");

        // Random halves, random lengths, random consumer stalls
        lat_chk = 0; rnd_ready = 1;
        for (int i = 0; i < 10; i++) send_half(16'($urandom), int'($urandom_range(8, 24)), 1);
        drain_wait("rand_drain");
        check("rand_ferr", 32'(frame_err), 32'(exp_ferr));
        check("rand_ovf", 32'(overflow), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
